// File: rtl/song_sequencer.sv
// song_sequencer: fetches a song of 4-bit note codes from an external
// registered ROM (1-cycle latency), keeps a 16-note look-ahead window,
// advances it one note per tempo beat and judges the player's pitch
// against the current note.
//
// Ports:
//   vclock, reset_n        clock (rising edge), async active-low reset
//   start, pause, tempo    song control; tempo is latched on start
//   rom_addr / rom_data    song ROM interface (4'hF = end of song)
//   detected_note/_valid   pitch-detector input
//   next_notes             window, [3:0] = current note
//   beat                   one-cycle pulse on each window advance
//   playing_correct, score judging results
//   busy, song_done        sequencer status
//
// Optional feature macro: SEQ_LOOP_EN -- when defined, an end-of-song code
// seen while running wraps the song back to address 0 instead of draining.
module song_sequencer #(
  parameter int          ADDR_WIDTH    = 8,
  parameter logic [25:0] TEMPO_DEFAULT = 26'd32_500_000,
  parameter logic [15:0] MATCH_HOLD    = 16'd1024,
  parameter int          SCORE_WIDTH   = 16
) (
  input  logic                   vclock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   pause,
  input  logic [25:0]            tempo,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  input  logic [3:0]             rom_data,
  input  logic [3:0]             detected_note,
  input  logic                   detected_valid,
  output logic [63:0]            next_notes,
  output logic                   beat,
  output logic                   playing_correct,
  output logic [SCORE_WIDTH-1:0] score,
  output logic                   busy,
  output logic                   song_done
);

  typedef enum logic [2:0] {S_IDLE, S_PRELOAD, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0]  PTR_ONE   = ADDR_WIDTH'(1);
  localparam logic [SCORE_WIDTH-1:0] SCORE_ONE = SCORE_WIDTH'(1);
  localparam logic [3:0]             EOS_CODE  = 4'hF;

  state_t                 state_q, state_d;
  logic [15:0][3:0]       win_q, win_d;
  logic [ADDR_WIDTH-1:0]  ptr_q, ptr_d;
  logic                   eos_q, eos_d;
  logic [25:0]            tempo_q, tempo_d;
  logic [25:0]            cnt_q, cnt_d;
  logic [3:0]             pf_q, pf_d;
  logic                   pf_wait_q, pf_wait_d;
  logic [4:0]             pre_cnt_q, pre_cnt_d;
  logic [15:0]            hold_q, hold_d;
  logic                   pc_q, pc_d;
  logic [SCORE_WIDTH-1:0] score_q, score_d;
  logic                   beat_q, beat_d;
  logic                   match;

  assign match = detected_valid && (detected_note == win_q[0]) && (win_q[0] != 4'h0);

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    ptr_d     = ptr_q;
    eos_d     = eos_q;
    tempo_d   = tempo_q;
    cnt_d     = cnt_q;
    pf_d      = pf_q;
    pf_wait_d = 1'b0;
    pre_cnt_d = pre_cnt_q;
    hold_d    = hold_q;
    score_d   = score_q;
    beat_d    = 1'b0;

    case (state_q)
      S_PRELOAD: begin
        // rom_addr follows ptr; data for the address issued in the previous
        // preload cycle lands in the slot one behind the cycle counter.
        pre_cnt_d = pre_cnt_q + 5'd1;
        if (pre_cnt_q < 5'd16) begin
          ptr_d = ptr_q + PTR_ONE;
        end
        if (pre_cnt_q != 5'd0) begin
          if (rom_data == EOS_CODE) begin
            // Remaining slots are already zero from the start clear.
            eos_d     = 1'b1;
            ptr_d     = ptr_q;
            state_d   = S_RUN;
            pf_wait_d = 1'b1;
          end else begin
            win_d[pre_cnt_q[3:0] - 4'd1] = rom_data;
          end
        end
        if (pre_cnt_q == 5'd16) begin
          state_d   = S_RUN;
          pf_wait_d = 1'b1;
        end
      end

      S_RUN, S_DRAIN: begin
        if (!pause) begin
          if (cnt_q == tempo_q - 26'd1) begin
            cnt_d  = '0;
            beat_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 26'd1;
          end
        end

        // rom_data reflects ptr once the cycle after a ptr change has
        // passed; the end-of-song code is caught here so it never enters pf.
        if (!eos_q && !pf_wait_q) begin
          if ((rom_data == EOS_CODE) || (ptr_q == '1)) begin
`ifdef SEQ_LOOP_EN
            ptr_d     = '0;
            pf_wait_d = 1'b1;
`else
            eos_d = 1'b1;
`endif
          end else begin
            pf_d = rom_data;
          end
        end

        if (beat_d) begin
          win_d = {(eos_q ? 4'h0 : pf_q), win_q[15:1]};
          if (!eos_q) begin
            ptr_d     = ptr_q + PTR_ONE;
            pf_wait_d = 1'b1;
          end
        end

        if (beat_d && eos_q && (win_d == '0)) begin
          state_d = S_DONE;
        end else if ((state_q == S_RUN) && eos_q) begin
          state_d = S_DRAIN;
        end
      end

      default: ;
    endcase

    // Hold counter restarts on each new note so a note must be held anew.
    if (beat_d || !match) begin
      hold_d = '0;
    end else if (hold_q != MATCH_HOLD) begin
      hold_d = hold_q + 16'd1;
    end
    pc_d = (hold_q == MATCH_HOLD);

    if (beat_d && pc_q && (score_q != '1)) begin
      score_d = score_q + SCORE_ONE;
    end

    // Restart overrides everything computed above, including a coincident beat.
    if (start) begin
      state_d   = S_PRELOAD;
      win_d     = '0;
      score_d   = '0;
      eos_d     = 1'b0;
      ptr_d     = '0;
      cnt_d     = '0;
      pre_cnt_d = '0;
      beat_d    = 1'b0;
      pf_d      = '0;
      pf_wait_d = 1'b0;
      hold_d    = '0;
      if (tempo == 26'd0) begin
        tempo_d = TEMPO_DEFAULT;
      end else if (tempo < 26'd4) begin
        tempo_d = 26'd4;
      end else begin
        tempo_d = tempo;
      end
    end
  end

  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      win_q     <= '0;
      ptr_q     <= '0;
      eos_q     <= 1'b0;
      tempo_q   <= TEMPO_DEFAULT;
      cnt_q     <= '0;
      pf_q      <= '0;
      pf_wait_q <= 1'b0;
      pre_cnt_q <= '0;
      hold_q    <= '0;
      pc_q      <= 1'b0;
      score_q   <= '0;
      beat_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      ptr_q     <= ptr_d;
      eos_q     <= eos_d;
      tempo_q   <= tempo_d;
      cnt_q     <= cnt_d;
      pf_q      <= pf_d;
      pf_wait_q <= pf_wait_d;
      pre_cnt_q <= pre_cnt_d;
      hold_q    <= hold_d;
      pc_q      <= pc_d;
      score_q   <= score_d;
      beat_q    <= beat_d;
    end
  end

  assign rom_addr        = ptr_q;
  assign next_notes      = win_q;
  assign beat            = beat_q;
  assign playing_correct = pc_q;
  assign score           = score_q;
  assign busy            = (state_q == S_PRELOAD) || (state_q == S_RUN) || (state_q == S_DRAIN);
  assign song_done       = (state_q == S_DONE);

endmodule
